// File: rtl/osc_capture_ctrl.sv
// Oscilloscope acquisition sequencer: arms, finds a level/edge (or timeout) trigger,
// then writes one decimated frame of DEPTH samples into the display buffer.
module osc_capture_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int TIMEOUT = 65535,
    parameter int HOLDOFF = 1000
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sample_valid,
    input  logic [7:0]        ad_data_in,
    input  logic [1:0]        h_zoom,
    input  logic [7:0]        trig_level,
    input  logic              trig_edge,
    input  logic              disp_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              auto_trig,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_TRIG = 3'd2,
        CAPTURE   = 3'd3,
        HOLD      = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [15:0]     TIMEOUT_C = 16'(TIMEOUT);
    localparam logic [15:0]     HOLDOFF_C = 16'(HOLDOFF);

    state_t          st;
    logic [7:0]      prev;
    logic            prev_valid;
    logic [15:0]     tmo_cnt;
    logic [15:0]     hold_cnt;
    logic [1:0]      zoom_q;
    logic [5:0]      dec_cnt;
    logic [ADDR_W:0] wr_cnt;

    logic            rise, fall, real_trig, timeout_hit;
    logic [15:0]     tmo_next;
    logic [5:0]      dec_mask, dec_next;

    assign state = st;

    assign rise        = prev_valid && (prev <  trig_level) && (ad_data_in >= trig_level);
    assign fall        = prev_valid && (prev >= trig_level) && (ad_data_in <  trig_level);
    assign real_trig   = trig_edge ? fall : rise;
    assign tmo_next    = tmo_cnt + 16'd1;
    assign timeout_hit = (tmo_next == TIMEOUT_C);

    // Ratios are powers of two, so the modulo counter is a plain mask.
    always_comb begin
        dec_mask = 6'h00;
        case (zoom_q)
            2'd0: dec_mask = 6'h00;
            2'd1: dec_mask = 6'h03;
            2'd2: dec_mask = 6'h0F;
            2'd3: dec_mask = 6'h3F;
            default: dec_mask = 6'h00;
        endcase
        dec_next = (dec_cnt + 6'd1) & dec_mask;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'd0;
            frame_done <= 1'b0;
            auto_trig  <= 1'b0;
            prev       <= 8'd0;
            prev_valid <= 1'b0;
            tmo_cnt    <= 16'd0;
            hold_cnt   <= 16'd0;
            zoom_q     <= 2'd0;
            dec_cnt    <= 6'd0;
            wr_cnt     <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (!en) begin
                st <= IDLE;
            end else begin
                case (st)
                    IDLE: st <= ARM;
                    ARM: begin
                        if (!disp_busy) begin
                            st         <= WAIT_TRIG;
                            prev_valid <= 1'b0;
                            tmo_cnt    <= 16'd0;
                        end
                    end
                    WAIT_TRIG: begin
                        if (sample_valid) begin
                            // A real trigger takes precedence over a coincident timeout.
                            if (real_trig || timeout_hit) begin
                                zoom_q    <= h_zoom;
                                auto_trig <= !real_trig;
                                dec_cnt   <= 6'd0;
                                wr_en     <= 1'b1;
                                wr_addr   <= '0;
                                wr_data   <= ad_data_in;
                                wr_cnt    <= (ADDR_W+1)'(1);
                                st        <= CAPTURE;
                            end else begin
                                prev       <= ad_data_in;
                                prev_valid <= 1'b1;
                                tmo_cnt    <= tmo_next;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (wr_cnt == DEPTH_C) begin
                            frame_done <= 1'b1;
                            wr_addr    <= '0;
                            wr_cnt     <= '0;
                            hold_cnt   <= 16'd0;
                            st         <= HOLD;
                        end else if (sample_valid) begin
                            dec_cnt <= dec_next;
                            if (dec_next == 6'd0) begin
                                wr_en   <= 1'b1;
                                wr_addr <= wr_cnt[ADDR_W-1:0];
                                wr_data <= ad_data_in;
                                wr_cnt  <= wr_cnt + 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (hold_cnt + 16'd1 >= HOLDOFF_C) st <= ARM;
                        else                               hold_cnt <= hold_cnt + 16'd1;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_osc_capture_ctrl.sv
// Directed bench for osc_capture_ctrl: scoreboarded buffer writes plus
// state/frame_done/auto_trig checks around triggers, holdoff, en drop and reset.
module tb_osc_capture_ctrl;

    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 1024;
    localparam int TIMEOUT = 16;
    localparam int HOLDOFF = 20;

    logic              clk_50M = 1'b0;
    logic              rst_n;
    logic              en;
    logic              sample_valid;
    logic [7:0]        ad_data_in;
    logic [1:0]        h_zoom;
    logic [7:0]        trig_level;
    logic              trig_edge;
    logic              disp_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_done;
    logic              auto_trig;
    logic [2:0]        state;

    typedef struct { int addr; int data; } wr_t;
    wr_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  fd_cnt = 0;

    osc_capture_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .en(en), .sample_valid(sample_valid),
        .ad_data_in(ad_data_in), .h_zoom(h_zoom), .trig_level(trig_level),
        .trig_edge(trig_edge), .disp_busy(disp_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_done(frame_done), .auto_trig(auto_trig), .state(state)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        sample_valid = 1'b1;
        ad_data_in   = d;
        @(negedge clk_50M);
    endtask

    task automatic push(input int a, input int d);
        wr_t e;
        e.addr = a;
        e.data = d & 255;
        q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string tag);
        int n = 0;
        while (state !== s && n < max) begin
            @(negedge clk_50M);
            n++;
        end
        chk(tag, state, s);
    endtask

    // Scoreboard: every write must match the oldest outstanding expectation.
    always @(negedge clk_50M) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                assert (q.size() != 0) else begin
                    bad++;
                    $error("FAIL spurious_wr got addr=%0d data=%0d exp none", wr_addr, wr_data);
                end
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
            end
        end
        if (rst_n === 1'b1 && frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; sample_valid = 1'b0; ad_data_in = 8'd0;
        h_zoom = 2'd0; trig_level = 8'd0; trig_edge = 1'b0; disp_busy = 1'b0;
        repeat (3) @(negedge clk_50M);
        chk("rst_state", state, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_auto_trig", auto_trig, 0);
        rst_n = 1'b1;
        @(negedge clk_50M);

        // Rising trigger, full-rate frame
        trig_level = 8'd128; trig_edge = 1'b0; h_zoom = 2'd0; en = 1'b1;
        @(negedge clk_50M); chk("arm", state, 1);
        @(negedge clk_50M); chk("wait_trig", state, 2);
        for (int v = 120; v < 128; v++) send(8'(v));
        push(0, 128); send(8'd128);
        for (int i = 1; i < DEPTH; i++) begin
            push(i, 128 + i);
            send(8'(128 + i));
        end
        sample_valid = 1'b0;
        chk("last_wr_en", wr_en, 1);
        chk("last_fd_low", frame_done, 0);
        @(negedge clk_50M);
        chk("fd_pulse", frame_done, 1);
        chk("fd_state_hold", state, 4);
        chk("fd_addr_zero", wr_addr, 0);
        chk("real_auto_trig", auto_trig, 0);

        // Holdoff length and display lockout in ARM; samples must be ignored
        disp_busy = 1'b1; sample_valid = 1'b1; ad_data_in = 8'd200;
        begin
            int hc = 0;
            while (state === 3'd4 && hc < 1000) begin
                hc++;
                @(negedge clk_50M);
            end
            chk("hold_len", hc, HOLDOFF);
        end
        chk("fd_single", frame_done, 0);
        repeat (5) begin
            chk("lock_state", state, 1);
            chk("lock_wr_en", wr_en, 0);
            @(negedge clk_50M);
        end
        sample_valid = 1'b0; disp_busy = 1'b0;
        @(negedge clk_50M); chk("unlock", state, 2);

        // Falling trigger with 1:16 decimation; h_zoom change ignored; en dropped
        trig_edge = 1'b1; trig_level = 8'd100; h_zoom = 2'd2;
        send(8'd110);
        push(0, 99); send(8'd99);
        for (int k = 1; k < 4800; k++) begin
            if (k == 40) h_zoom = 2'd0;
            if (k % 16 == 0) push(k / 16, k * 3);
            send(8'(k * 3));
        end
        en = 1'b0;
        send(8'(4800 * 3));
        chk("drop_idle", state, 0);
        chk("drop_wr_en", wr_en, 0);
        for (int k = 4801; k < 4840; k++) send(8'(k * 3));
        sample_valid = 1'b0;
        chk("drop_no_fd", fd_cnt, 1);
        chk("drop_auto_hold", auto_trig, 0);

        // Auto-trigger; first sample equals level with a stale prev below it
        trig_level = 8'd200; trig_edge = 1'b0; h_zoom = 2'd0; en = 1'b1;
        @(negedge clk_50M); chk("reen_arm", state, 1);
        @(negedge clk_50M); chk("reen_wait", state, 2);
        send(8'd200);
        repeat (14) send(8'd50);
        chk("no_early_trig", state, 2);
        push(0, 50); send(8'd50);
        for (int i = 1; i < DEPTH; i++) begin
            push(i, i);
            send(8'(i));
        end
        sample_valid = 1'b0;
        chk("auto_last_addr", wr_addr, DEPTH - 1);
        @(negedge clk_50M);
        chk("auto_fd", frame_done, 1);
        chk("auto_trig_set", auto_trig, 1);
        wait_state(3'd2, 200, "auto_rearm");

        // Real trigger then asynchronous reset at write 500
        trig_level = 8'd128;
        send(8'd100);
        push(0, 130); send(8'd130);
        chk("auto_trig_clr", auto_trig, 0);
        for (int i = 1; i <= 500; i++) begin
            push(i, 130 + i);
            send(8'(130 + i));
        end
        sample_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_wr_en", wr_en, 0);
        chk("arst_wr_addr", wr_addr, 0);
        chk("arst_wr_data", wr_data, 0);
        chk("arst_fd", frame_done, 0);
        chk("arst_auto", auto_trig, 0);
        @(negedge clk_50M); rst_n = 1'b1;
        @(negedge clk_50M); chk("post_rst_arm", state, 1);
        @(negedge clk_50M); chk("post_rst_wait", state, 2);
        send(8'd10);
        push(0, 200); send(8'd200);
        push(1, 201); send(8'd201);
        push(2, 202); send(8'd202);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk_50M);
        chk("fd_total", fd_cnt, 2);
        chk("queue_drained", q.size(), 0);
        en = 1'b0;
        @(negedge clk_50M); chk("final_idle", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/osc_capture_ctrl.md
Name: osc_capture_ctrl

Overview:
Sequences oscilloscope acquisition of ADC samples into the waveform display buffer. Arms when oscilloscope mode is active, detects a level/edge trigger, or auto-triggers after a timeout. It then writes one decimated frame of DEPTH samples and hands the frame to the HDMI display path. It sits between the ADC front end (ad_data_in) and the display RAM that hdmi_dis_top reads. It takes its horizontal zoom from the OSI menu counters.

Parameters:
ADDR_W, 10, buffer address width
DEPTH, 1024, samples per frame; legal range 2..2^ADDR_W
TIMEOUT, 65535, valid samples in WAIT_TRIG before auto-trigger (16-bit counter)
HOLDOFF, 1000, clk_50M cycles spent in HOLD after a frame (16-bit counter)

Ports:
clk_50M  in  1  system clock
rst_n  in  1  reset
en  in  1  oscilloscope mode active
sample_valid  in  1  one-cycle strobe: ad_data_in holds a new sample
ad_data_in  in  8  unsigned ADC sample
h_zoom  in  2  decimation select: 0:1, 1:4, 2:16, 3:64
trig_level  in  8  unsigned trigger threshold
trig_edge  in  1  0 rising, 1 falling
disp_busy  in  1  display is reading buffer; no writes may start while high
wr_en  out  1  buffer write strobe
wr_addr  out  ADDR_W  buffer write address
wr_data  out  8  buffer write data
frame_done  out  1  one-cycle pulse: frame complete
auto_trig  out  1  last/current frame was auto-triggered
state  out  3  current FSM state, for debug/display

Behaviour:
- One clock, clk_50M. Reset is asynchronous and active-low on rst_n. All flops are cleared on rst_n low.
- Reset values: state=IDLE(0), wr_en=0, wr_addr=0, wr_data=0, frame_done=0, auto_trig=0. Internal counters, prev-sample and prev_valid are all 0.
- State encoding: IDLE=0, ARM=1, WAIT_TRIG=2, CAPTURE=3, HOLD=4.
- en=0 in any state forces IDLE on the next edge:
  - any write in flight is dropped (wr_en=0 that cycle);
  - no frame_done pulse;
  - auto_trig holds its value.
- IDLE: if en=1, go to ARM.
- ARM: if disp_busy=0, go to WAIT_TRIG. On entry to WAIT_TRIG, clear prev_valid and the timeout counter.
- WAIT_TRIG: operates on every sample_valid (no decimation).
  - Rising trigger: prev_valid=1, prev<trig_level, and ad_data_in>=trig_level.
  - Falling trigger: prev_valid=1, prev>=trig_level, and ad_data_in<trig_level.
  - On a valid sample without a trigger: store prev=ad_data_in, set prev_valid=1, increment the timeout counter.
  - If the counter reaches TIMEOUT on a valid sample without a trigger, that sample is treated as an auto-trigger.
  - If a real trigger and the timeout coincide, the real trigger wins (auto_trig=0).
- On a trigger (real or auto), all in the same edge:
  - latch h_zoom into the decimation ratio;
  - set auto_trig (1 for auto, 0 for real);
  - reset the decimation counter;
  - write the trigger sample at address 0;
  - go to CAPTURE.
- CAPTURE: the decimation counter counts sample_valid events modulo the latched ratio. A sample is written when the counter equals 0.
  - Changes to h_zoom during CAPTURE are ignored.
  - A disp_busy rise during CAPTURE is ignored (the frame must finish).
- Write timing: wr_en, wr_addr and wr_data are registered. They are asserted for exactly one cycle, on the cycle after the qualifying sample_valid. wr_data equals the qualifying ad_data_in.
- wr_addr increments after each write and runs 0..DEPTH-1 with no wrap within a frame.
- The write at address DEPTH-1 is followed, on the next cycle, by a frame_done pulse (1 cycle) and the move to HOLD. wr_addr returns to 0.
- HOLD: waits HOLDOFF cycles, then goes to ARM.
- sample_valid in IDLE, ARM and HOLD is ignored.

Test Plan:
- Reset mid-CAPTURE (rst_n low at write 500, async) -> all outputs 0 immediately. After release with en=1: IDLE->ARM->WAIT_TRIG; the next frame starts at wr_addr 0.
- Rising trigger: trig_level=128, trig_edge=0, h_zoom=0, samples ramp 120..131 then continue -> trigger on sample 128, wr_addr 0 gets 128. Then 1024 consecutive writes with data incrementing. frame_done pulses 1 cycle after write 1023. auto_trig=0.
- Falling edge plus decimation: trig_edge=1, trig_level=100, h_zoom=2, samples 110 then 99 then a ramp -> address 0=99, address 1 = the 16th sample after the trigger. Toggling h_zoom to 0 mid-frame does not change the spacing.
- Auto-trigger: constant input 50, trig_level=200, TIMEOUT=16 -> auto-trigger on the 16th valid sample in WAIT_TRIG, auto_trig=1, frame completes normally. A first sample equal to trig_level must not trigger (prev_valid=0).
- Display lockout plus holdoff: disp_busy=1 during HOLD and ARM -> remains in ARM with wr_en=0 until disp_busy falls. HOLD lasts exactly HOLDOFF cycles after frame_done.
- en dropped mid-capture at write 300 -> IDLE next cycle, no further wr_en, no frame_done. Re-enable -> a fresh frame from address 0.
